spi_adc_sequencer: RTL and testbench
====================================

SPI_ADC_SEQUENCER -- requirements
Module: spi_adc_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of ADC channels scanned per sweep, range 1..8.
REQ-002 Parameter SCAN_PERIOD, default 2400: clk cycles between sweep starts, minimum 2.
REQ-003 Parameter CMD_PREFIX, default 4'b0001: bits [15:12] of every command word.
REQ-004 Parameter TIMEOUT, default 4096: clk cycles allowed per transfer (used only with SPI_SEQ_TIMEOUT_EN).
REQ-005 clk  input  1  system clock, the same clock that feeds the SPI master; single clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high allows sweeps to start; low stops new sweeps only.
REQ-008 start_transfer  output  1  request to the SPI master.
REQ-009 data_to_tx  output  16  command word to the SPI master.
REQ-010 data_rx  input  16  received word from the SPI master.
REQ-011 transfer_done  input  1  SPI completion level; may stay high for many clk cycles.
REQ-012 transfer_busy  input  1  SPI busy level.
REQ-013 sample_valid  output  1  one-clk pulse marking a new sample.
REQ-014 sample_ch  output  3  channel index of the current sample.
REQ-015 sample_data  output  12  conversion result.
REQ-016 scan_done  output  1  one-clk pulse when the last channel of a sweep is stored.
REQ-017 overrun  output  1  sticky flag: a sweep tick arrived while a sweep was still in progress.
REQ-018 timeout_err  output  1  sticky flag for a transfer timeout; tied 0 without SPI_SEQ_TIMEOUT_EN.

Function
REQ-019 The period counter SHALL run from 0 to SCAN_PERIOD-1, wrap to 0, and raise a tick when it wraps; it runs regardless of enable.
REQ-020 The state machine SHALL have states IDLE, REQ, WAIT, STORE and NEXT.
REQ-021 IDLE -> REQ on a tick with enable=1; channel index set to 0.
REQ-022 REQ: start_transfer=1 and data_to_tx={CMD_PREFIX, ch[2:0], 9'b0}, both held until transfer_busy=1 is sampled; then -> WAIT with start_transfer=0 on the next cycle.
REQ-023 WAIT -> STORE on the rising edge of transfer_done, detected from a registered copy of the previous value.
REQ-024 STORE: capture sample_data=data_rx[11:0] and sample_ch=ch; assert sample_valid for exactly one cycle, in the cycle after entering STORE.
REQ-025 NEXT: if ch==NUM_CH-1, pulse scan_done and go to IDLE; otherwise increment ch and go to REQ.
REQ-026 A tick seen in any state other than IDLE SHALL set overrun; the current sweep continues and the tick is dropped.
REQ-027 enable falling mid-sweep SHALL let the sweep finish.
REQ-028 sample_data and sample_ch SHALL hold their values between sample_valid pulses.
REQ-029 data_to_tx SHALL be 16'h0000 outside REQ.
REQ-030 transfer_done already high on entry to WAIT (stale from the previous transfer) SHALL NOT count as completion.

Reset
REQ-031 reset SHALL clear all registers asynchronously and return the state machine to IDLE.
REQ-032 Outputs held in reset: start_transfer=0, data_to_tx=0, sample_valid=0, sample_ch=0, sample_data=0, scan_done=0, overrun=0, timeout_err=0; period counter=0.
REQ-033 Reset mid-transfer SHALL abandon the sweep; after release the first sweep starts on the next tick.

Configuration
REQ-034 Macro SPI_SEQ_TIMEOUT_EN defined: a per-transfer counter cleared on entry to REQ counts cycles spent in REQ and WAIT.
REQ-035 If that counter reaches TIMEOUT: set timeout_err, deassert start_transfer, go to IDLE, produce no sample_valid and no scan_done.
REQ-036 Macro SPI_SEQ_TIMEOUT_EN undefined: no timeout counter is built, timeout_err is constant 0, and the block waits indefinitely.

Verification
REQ-037 NUM_CH=4 with an SPI model returning 16'h0ABC -> four sample_valid pulses with ch 0,1,2,3, sample_data=12'hABC, one scan_done, and data_to_tx 16'h1000/1200/1400/1600.
REQ-038 transfer_done held high for 10 clk -> exactly one sample_valid per transfer.
REQ-039 SCAN_PERIOD=50 with a sweep longer than 50 clk -> overrun=1 and the sweep still completes all channels.
REQ-040 reset asserted while in WAIT -> all outputs return to their reset values immediately; the next sweep starts cleanly at ch 0.
REQ-041 With SPI_SEQ_TIMEOUT_EN and TIMEOUT=100, transfer_done never asserted -> timeout_err=1 at cycle 100, state IDLE, no sample_valid.
REQ-042 enable=0 -> no start_transfer for 3 periods; enable=1 -> a sweep starts on the next tick.

Source files
------------

// File: rtl/spi_adc_sequencer.sv
// Periodic SPI ADC channel sweeper: issues one command per channel and publishes each result.
// Define SPI_SEQ_TIMEOUT_EN to build the per-transfer timeout watchdog.
module spi_adc_sequencer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SCAN_PERIOD = 2400,
  parameter logic [3:0]  CMD_PREFIX  = 4'b0001,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        start_transfer,
  output logic [15:0] data_to_tx,
  input  logic [15:0] data_rx,
  input  logic        transfer_done,
  input  logic        transfer_busy,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        scan_done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned PeriodW = $clog2(SCAN_PERIOD);
  localparam logic [PeriodW-1:0] PeriodMax = PeriodW'(SCAN_PERIOD - 1);
  localparam logic [2:0] LastCh = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StStore, StNext} state_e;

  state_e             state_q, state_d;
  logic [PeriodW-1:0] period_q;
  logic [2:0]         ch_q, ch_d;
  logic               tick;
  logic               done_q;
  logic               done_rise;
  logic               to_hit;
  logic               sample_valid_q;
  logic [2:0]         sample_ch_q;
  logic [11:0]        sample_data_q;
  logic               overrun_q;
  logic               unused_rx;

  assign tick      = (period_q == PeriodMax);
  // A done level left over from the previous transfer must not count, so only edges qualify.
  assign done_rise = transfer_done & ~done_q;
  assign unused_rx = ^data_rx[15:12];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q       <= '0;
      state_q        <= StIdle;
      ch_q           <= '0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      overrun_q      <= 1'b0;
    end else begin
      period_q       <= tick ? '0 : period_q + 1'b1;
      state_q        <= state_d;
      ch_q           <= ch_d;
      done_q         <= transfer_done;
      sample_valid_q <= (state_q == StStore);
      if (state_q == StStore) begin
        sample_ch_q   <= ch_q;
        sample_data_q <= data_rx[11:0];
      end
      if (tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    start_transfer = 1'b0;
    data_to_tx     = 16'h0000;
    scan_done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d = StReq;
          ch_d    = '0;
        end
      end
      StReq: begin
        start_transfer = 1'b1;
        data_to_tx     = {CMD_PREFIX, ch_q, 9'b0};
        if (transfer_busy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (done_rise) begin
          state_d = StStore;
        end
      end
      StStore: state_d = StNext;
      StNext: begin
        if (ch_q == LastCh) begin
          scan_done = 1'b1;
          state_d   = StIdle;
        end else begin
          ch_d    = ch_q + 3'd1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_hit) begin
      state_d = StIdle;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           timeout_q;

  // Counts cycles spent in REQ and WAIT for the current transfer.
  assign to_hit = ((state_q == StReq) || (state_q == StWait)) &&
                  (to_cnt_q == ToW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_d == StReq) && (state_q != StReq)) begin
        to_cnt_q <= '0;
      end else if ((state_q == StReq) || (state_q == StWait)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (to_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Bench for spi_adc_sequencer: SPI slave model, cycle-level expectation model and directed tests.
module tb_spi_adc_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned PER = 50;
  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        start_transfer, transfer_done, transfer_busy;
  logic        sample_valid, scan_done, overrun, timeout_err;
  logic [15:0] data_to_tx, data_rx;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_adc_sequencer #(
    .NUM_CH      (NCH),
    .SCAN_PERIOD (PER),
    .CMD_PREFIX  (4'b0001),
    .TIMEOUT     (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .start_transfer (start_transfer),
    .data_to_tx     (data_to_tx),
    .data_rx        (data_rx),
    .transfer_done  (transfer_done),
    .transfer_busy  (transfer_busy),
    .sample_valid   (sample_valid),
    .sample_ch      (sample_ch),
    .sample_data    (sample_data),
    .scan_done      (scan_done),
    .overrun        (overrun),
    .timeout_err    (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cmd_word(input logic [2:0] c);
    return 16'h1000 + 16'(c) * 16'h0200;
  endfunction

  // SPI slave: acks a request with busy, later raises done for done_len cycles with a result.
  int   ack_dly = 1, busy_len = 2, done_len = 10;
  bit   rx_vary = 1'b0, spi_mute = 1'b0;
  int   sp_ph = 0, sp_cnt = 0, done_left = 0;
  logic [15:0] sp_cmd;

  initial begin
    transfer_busy = 1'b0;
    transfer_done = 1'b0;
    data_rx       = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sp_ph = 0; transfer_busy = 1'b0; transfer_done = 1'b0; done_left = 0;
      end else begin
        case (sp_ph)
          0: if (start_transfer) begin sp_cmd = data_to_tx; sp_cnt = ack_dly; sp_ph = 1; end
          1: if (sp_cnt == 0) begin transfer_busy = 1'b1; sp_cnt = busy_len; sp_ph = 2; end
             else sp_cnt--;
          2: if (sp_cnt > 0) sp_cnt--;
             else if (!transfer_done && !spi_mute) begin
               transfer_busy = 1'b0;
               transfer_done = 1'b1;
               done_left     = done_len + 1;
               data_rx       = rx_vary ? {4'hF, 1'b0, sp_cmd[11:9], 8'h5A} : 16'h0ABC;
               sp_ph         = 0;
             end
          default: sp_ph = 0;
        endcase
        if (done_left > 0) begin
          done_left--;
          if (done_left == 0) transfer_done = 1'b0;
        end
      end
    end
  end

  // Expectation model, tracked per cycle from observable protocol events.
  bit          chk_en = 1'b1;
  int          cyc = 0;
  bit          m_sweep, m_req, m_wait, m_store, m_valid, m_scan, m_ovr, last_done;
  bit          nxt_valid, nxt_scan, tick;
  logic [2:0]  m_ch, m_sch;
  logic [11:0] m_sdata;

  int          n_valid = 0, n_scan = 0, n_start = 0;
  logic        prev_start = 1'b0;
  logic [2:0]  got_ch[$];
  logic [11:0] got_data[$];
  logic [15:0] got_cmd[$];

  always @(negedge clk) begin
    if (sample_valid) begin n_valid++; got_ch.push_back(sample_ch); got_data.push_back(sample_data); end
    if (scan_done) n_scan++;
    if (start_transfer) n_start++;
    if (start_transfer && !prev_start) got_cmd.push_back(data_to_tx);
    prev_start = start_transfer;

    if (reset) begin
      m_sweep = 0; m_req = 0; m_wait = 0; m_store = 0; m_valid = 0; m_scan = 0; m_ovr = 0;
      last_done = 0; m_ch = '0; m_sch = '0; m_sdata = '0; cyc = 0;
      if (chk_en) begin
        chk("rst_start", 32'(start_transfer), 32'd0);
        chk("rst_tx", 32'(data_to_tx), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
      end
    end else begin
      if (chk_en) begin
        chk("start_transfer", 32'(start_transfer), 32'(m_req));
        chk("data_to_tx", 32'(data_to_tx), 32'(m_req ? cmd_word(m_ch) : 16'h0000));
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("sample_ch", 32'(sample_ch), 32'(m_sch));
        chk("sample_data", 32'(sample_data), 32'(m_sdata));
        chk("scan_done", 32'(scan_done), 32'(m_scan));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout_err", 32'(timeout_err), 32'd0);
      end
      tick      = ((cyc % PER) == PER - 1);
      nxt_valid = 1'b0;
      nxt_scan  = 1'b0;
      if (tick && m_sweep) m_ovr = 1'b1;
      if (m_valid) begin
        if (m_ch == 3'(NCH - 1)) m_sweep = 1'b0;
        else begin m_ch = m_ch + 3'd1; m_req = 1'b1; end
      end else if (m_store) begin
        m_store   = 1'b0;
        nxt_valid = 1'b1;
        m_sch     = m_ch;
        m_sdata   = data_rx[11:0];
        nxt_scan  = (m_ch == 3'(NCH - 1));
      end else if (m_wait && transfer_done && !last_done) begin
        m_wait = 1'b0; m_store = 1'b1;
      end else if (m_req && transfer_busy) begin
        m_req = 1'b0; m_wait = 1'b1;
      end else if (!m_sweep && tick && enable) begin
        m_sweep = 1'b1; m_ch = '0; m_req = 1'b1;
      end
      m_valid   = nxt_valid;
      m_scan    = nxt_scan;
      last_done = transfer_done;
      cyc++;
    end
  end

  task automatic clear_mon();
    n_valid = 0; n_scan = 0; n_start = 0;
    got_ch.delete(); got_data.delete(); got_cmd.delete();
  endtask

  task automatic wait_scan(input int budget, input string name);
    int k = 0;
    while (n_scan < 1 && k < budget) begin @(posedge clk); #1; k++; end
    chk({name, "_scan_seen"}, 32'(n_scan >= 1), 32'd1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  logic [15:0] exp_cmd [4] = '{16'h1000, 16'h1200, 16'h1400, 16'h1600};

  initial begin
    int k;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_sample_ch", 32'(sample_ch), 32'd0);
    chk("reset_sample_data", 32'(sample_data), 32'd0);
    chk("reset_scan_done", 32'(scan_done), 32'd0);
    release_reset();

    // Basic sweep, fixed result, done held 10 cycles (stale on the next WAIT entry).
    clear_mon();
    @(posedge clk); #1;
    enable = 1'b1;
    wait_scan(300, "t1");
    enable = 1'b0;
    chk("t1_valid_count", 32'(n_valid), 32'd4);
    chk("t1_scan_count", 32'(n_scan), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_ch", 32'(got_ch[i]), 32'(i));
      chk("t1_data", 32'(got_data[i]), 32'h0ABC);
      chk("t1_cmd", 32'(got_cmd[i]), 32'(exp_cmd[i]));
    end

    // Slow transfers make the sweep outlast the period.
    clear_mon();
    busy_len = 20;
    rx_vary  = 1'b1;
    enable   = 1'b1;
    wait_scan(500, "t2");
    enable = 1'b0;
    chk("t2_overrun", 32'(overrun), 32'd1);
    chk("t2_valid_count", 32'(n_valid), 32'd4);
    chk("t2_ch3", 32'(got_ch[3]), 32'd3);
    chk("t2_data_ch2", 32'(got_data[2]), 32'h25A);
    chk("t2_data_ch3", 32'(got_data[3]), 32'h35A);

    // Disabled for three periods, then enable.
    busy_len = 2;
    rx_vary  = 1'b0;
    repeat (5) @(posedge clk);
    clear_mon();
    repeat (3 * PER) @(posedge clk);
    #1;
    chk("t3_no_start", 32'(n_start), 32'd0);
    enable = 1'b1;
    k = 0;
    while (n_start == 0 && k < PER + 5) begin @(posedge clk); #1; k++; end
    chk("t3_started", 32'(n_start > 0), 32'd1);

    // Reset while waiting for the first transfer of that sweep.
    k = 0;
    while (start_transfer && k < 50) begin @(posedge clk); #1; k++; end
    #1 reset = 1'b1;
    #1;
    chk("t3_rst_overrun", 32'(overrun), 32'd0);
    chk("t3_rst_start", 32'(start_transfer), 32'd0);
    chk("t3_rst_data", 32'(sample_data), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    clear_mon();
    wait_scan(300, "t3");
    enable = 1'b0;
    chk("t3_valid_count", 32'(n_valid), 32'd4);
    chk("t3_first_ch", 32'(got_ch[0]), 32'd0);
    chk("t3_last_ch", 32'(got_ch[3]), 32'd3);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Transfer that never completes.
    chk_en   = 1'b0;
    spi_mute = 1'b1;
    repeat (3) @(posedge clk);
    clear_mon();
    enable = 1'b1;
    k = 0;
    while (!start_transfer && k < 2 * PER) begin @(negedge clk); k++; end
    chk("t4_started", 32'(start_transfer), 32'd1);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 99) chk("t4_err_c99", 32'(timeout_err), 32'd0);
      if (n == 100) begin
        chk("t4_err_c100", 32'(timeout_err), 32'd1);
        chk("t4_start_c100", 32'(start_transfer), 32'd0);
      end
    end
    enable = 1'b0;
    chk("t4_no_valid", 32'(n_valid), 32'd0);
    chk("t4_no_scan", 32'(n_scan), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    spi_mute = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    chk_en = 1'b1;
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
